// File: rtl/aes_stream_pkg.sv
// Shared widths and FSM state encoding for the word-serial AES-256 stream wrapper.
package aes_stream_pkg;

    localparam int BLOCK_W         = 128;
    localparam int KEY_W           = 256;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/aes_word_stream.sv
// Word-serial load/settle/drain wrapper around an external combinational AES-256 core.
// Optional block counter output enabled by defining AES_STREAM_CNT_EN.
module aes_word_stream
    import aes_stream_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_we,
    input  logic [KEY_W-1:0]     key_in,
    output logic                 idle,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_data,
    output logic [BLOCK_W-1:0]   aes_message,
    output logic [KEY_W-1:0]     aes_key,
    input  logic [BLOCK_W-1:0]   aes_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
`ifdef AES_STREAM_CNT_EN
    output logic [31:0]          blk_count,
`endif
    output logic                 out_last
);

    localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t               state_r;
    state_t               state_s;
    logic [1:0]           wcnt_r;
    logic [1:0]           ocnt_r;
    logic [SCNT_W-1:0]    scnt_r;
    logic [BLOCK_W-1:0]   result_r;
    logic                 in_fire_s;
    logic                 out_fire_s;

    assign in_ready   = (state_r == LOAD);
    assign idle       = (state_r == LOAD) && (wcnt_r == 2'd0);
    assign out_valid  = (state_r == DRAIN);
    assign out_last   = (state_r == DRAIN) && (ocnt_r == 2'd3);
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid && out_ready;

    // Next-state logic for the load/settle/drain sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (in_fire_s && (wcnt_r == 2'd3)) state_s = SETTLE;
                else                              state_s = LOAD;
            end
            SETTLE: begin
                if (scnt_r == SCNT_W'(0)) state_s = DRAIN;
                else                      state_s = SETTLE;
            end
            DRAIN: begin
                if (out_fire_s && (ocnt_r == 2'd3)) state_s = LOAD;
                else                               state_s = DRAIN;
            end
            default: state_s = LOAD;
        endcase
    end

    // Output word select; word 0 is the most significant result word.
    always_comb begin
        out_data = result_r[31:0];
        case (ocnt_r)
            2'd0:    out_data = result_r[127:96];
            2'd1:    out_data = result_r[95:64];
            2'd2:    out_data = result_r[63:32];
            default: out_data = result_r[31:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= LOAD;
        else     state_r <= state_s;
    end

    // Key and message capture; both only move while in LOAD, which keeps the core inputs stable during SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            aes_key     <= {KEY_W{1'b0}};
            aes_message <= {BLOCK_W{1'b0}};
            wcnt_r      <= 2'd0;
        end else begin
            if (key_we && idle) aes_key <= key_in;
            if (in_fire_s) begin
                case (wcnt_r)
                    2'd0:    aes_message[127:96] <= in_data;
                    2'd1:    aes_message[95:64]  <= in_data;
                    2'd2:    aes_message[63:32]  <= in_data;
                    default: aes_message[31:0]   <= in_data;
                endcase
                wcnt_r <= wcnt_r + 2'd1;
            end
        end
    end

    // Settle countdown and result capture at the end of the multicycle window.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_r   <= SCNT_W'(0);
            result_r <= {BLOCK_W{1'b0}};
        end else if (in_fire_s && (wcnt_r == 2'd3)) begin
            scnt_r <= SCNT_W'(SETTLE_CYCLES - 1);
        end else if (state_r == SETTLE) begin
            if (scnt_r != SCNT_W'(0)) scnt_r   <= scnt_r - SCNT_W'(1);
            else                      result_r <= aes_out;
        end
    end

    // Output word counter; wraps back to 0 with the last handshake.
    always_ff @(posedge clk) begin
        if (rst)             ocnt_r <= 2'd0;
        else if (out_fire_s) ocnt_r <= ocnt_r + 2'd1;
    end

`ifdef AES_STREAM_CNT_EN
    // Completed-block counter, free-running with natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (rst)                             blk_count <= 32'd0;
        else if (out_fire_s && out_last)     blk_count <= blk_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_aes_word_stream.sv
// Self-checking bench for aes_word_stream with a stand-in core model and a block-level reference.
module tb_aes_word_stream;

    localparam int SETTLE = 4;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_we = 1'b0;
    logic [255:0] key_in = '0;
    logic         idle;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic [127:0] aes_message;
    logic [255:0] aes_key;
    logic [127:0] aes_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
`ifdef AES_STREAM_CNT_EN
    logic [31:0]  blk_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [255:0] key_model = '0;

    // Stand-in for the AES-256 core: the FIPS-197 answer for the known vector, a keyed mix otherwise.
    function automatic logic [127:0] core_model(input logic [127:0] msg, input logic [255:0] key);
        if (msg == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return msg ^ key[255:128] ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
    endfunction

    assign aes_out = core_model(aes_message, aes_key);

    aes_word_stream #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .key_we(key_we), .key_in(key_in), .idle(idle),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .aes_message(aes_message), .aes_key(aes_key), .aes_out(aes_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_STREAM_CNT_EN
        .blk_count(blk_count),
`endif
        .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_state(input string name);
        vectors++;
        if (idle !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: idle/in_ready/out_valid/out_last got %b%b%b%b expected 1100",
                     name, idle, in_ready, out_valid, out_last);
        end
    endtask

    task automatic load_key(input logic [255:0] k);
        key_we = 1'b1;
        key_in = k;
        step();
        key_we = 1'b0;
        key_model = k;
        vectors++;
        if (aes_key !== k) begin
            miscompares++;
            $display("FAIL load_key: got %h expected %h", aes_key, k);
        end
    endtask

    // Offer one word; in LOAD it must be accepted on the next edge.
    task automatic send_word(input logic [31:0] w, input bit kw, input logic [255:0] k, input int gap_max);
        repeat ($urandom_range(gap_max, 0)) step();
        in_valid = 1'b1;
        in_data  = w;
        if (kw) begin
            key_we = 1'b1;
            key_in = k;
            key_model = k;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_word: in_ready got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        key_we   = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] msg, input bit kw, input logic [255:0] k,
                              input int gap_max, output int e_cyc);
        for (int w = 0; w < 4; w++)
            send_word(msg[(3-w)*32 +: 32], kw && (w == 0), k, gap_max);
        e_cyc = cyc;
    endtask

    // Wait for the result, optionally check latency, then drain and compare all four words.
    task automatic recv_block(input logic [127:0] ct, input int e_cyc, input bit chk_lat, input bit bp);
        int budget = 0;
        while (out_valid !== 1'b1 && budget < 50) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL settle_in_ready: got %b expected 0", in_ready);
            end
            step();
            budget++;
        end
        if (budget >= 50) begin
            miscompares++;
            $display("FAIL out_valid_timeout: got 0 after %0d cycles expected 1", budget);
        end
        if (chk_lat) begin
            vectors++;
            if (cyc - e_cyc != SETTLE) begin
                miscompares++;
                $display("FAIL latency: got %0d expected %0d", cyc - e_cyc, SETTLE);
            end
        end
        for (int w = 0; w < 4; w++) begin
            int guard = 0;
            bit done = 1'b0;
            while (!done) begin
                out_ready = bp ? ($urandom_range(1, 0) == 1) : 1'b1;
                vectors++;
                if (out_valid !== 1'b1 || out_data !== ct[(3-w)*32 +: 32] || out_last !== (w == 3)
                    || in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL out_word%0d: valid/data/last/in_ready got %b/%h/%b/%b expected 1/%h/%b/0",
                             w, out_valid, out_data, out_last, in_ready, ct[(3-w)*32 +: 32], w == 3);
                end
                done = out_ready;
                step();
                guard++;
                if (guard > 40) begin
                    miscompares++;
                    $display("FAIL out_stall_timeout: word %0d got no handshake expected one", w);
                    done = 1'b1;
                end
            end
        end
        out_ready = 1'b0;
        check_idle_state("post_drain");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_state("reset");
        vectors++;
        if (aes_message !== 128'd0 || aes_key !== 256'd0 || out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_regs: msg/key/out_data got %h/%h/%h expected zero", aes_message, aes_key, out_data);
        end
    endtask

    task automatic test_fips();
        int e;
        load_key(FIPS_KEY);
        send_block(FIPS_PT, 1'b0, '0, 0, e);
        vectors++;
        if (aes_message !== FIPS_PT) begin
            miscompares++;
            $display("FAIL fips_message: got %h expected %h", aes_message, FIPS_PT);
        end
        recv_block(FIPS_CT, e, 1'b1, 1'b0);
    endtask

    task automatic test_back_pressure();
        int e;
        send_block(FIPS_PT, 1'b0, '0, 0, e);
        recv_block_wait: for (int i = 0; i < 50 && out_valid !== 1'b1; i++) step();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'h8ea2b7ca || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL back_pressure: valid/data/in_ready got %b/%h/%b expected 1/8ea2b7ca/0",
                         out_valid, out_data, in_ready);
            end
            step();
        end
        recv_block(FIPS_CT, e, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_key();
        int e;
        send_word(FIPS_PT[127:96], 1'b0, '0, 0);
        send_word(FIPS_PT[95:64], 1'b0, '0, 0);
        key_we = 1'b1;
        key_in = {256{1'b1}};
        step();
        key_we = 1'b0;
        vectors++;
        if (aes_key !== FIPS_KEY || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_key: key/idle got %h/%b expected %h/0", aes_key, idle, FIPS_KEY);
        end
        send_word(FIPS_PT[63:32], 1'b0, '0, 0);
        send_word(FIPS_PT[31:0], 1'b0, '0, 0);
        e = cyc;
        recv_block(FIPS_CT, e, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_settle();
        int e;
        send_block(FIPS_PT, 1'b0, '0, 0, e);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_state("mid_settle_reset");
        vectors++;
        if (aes_message !== 128'd0 || aes_key !== 256'd0) begin
            miscompares++;
            $display("FAIL mid_settle_regs: msg/key got %h/%h expected zero", aes_message, aes_key);
        end
        load_key(FIPS_KEY);
        send_block(FIPS_PT, 1'b0, '0, 0, e);
        recv_block(FIPS_CT, e, 1'b1, 1'b0);
    endtask

    // Random keys and blocks, random input gaps and output back-pressure, key sometimes with first word.
    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            logic [127:0] msg;
            logic [255:0] k;
            int e;
            int mode;
            msg  = {$urandom, $urandom, $urandom, $urandom};
            k    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            mode = $urandom_range(2, 0);
            if (mode == 1) load_key(k);
            send_block(msg, mode == 2, k, 2, e);
            vectors++;
            if (aes_key !== key_model || aes_message !== msg) begin
                miscompares++;
                $display("FAIL random_inputs%0d: key/msg got %h/%h expected %h/%h", b, aes_key, aes_message, key_model, msg);
            end
            recv_block(core_model(msg, key_model), e, 1'b1, 1'b1);
        end
    endtask

`ifdef AES_STREAM_CNT_EN
    task automatic test_blk_count();
        int e;
        test_reset();
        load_key(FIPS_KEY);
        for (int b = 0; b < 3; b++) begin
            send_block(FIPS_PT, 1'b0, '0, 0, e);
            recv_block(FIPS_CT, e, 1'b1, 1'b0);
        end
        vectors++;
        if (blk_count !== 32'd3) begin
            miscompares++;
            $display("FAIL blk_count3: got %0d expected 3", blk_count);
        end
        force dut.blk_count = 32'hFFFF_FFFF;
        #1;
        release dut.blk_count;
        send_block(FIPS_PT, 1'b0, '0, 0, e);
        recv_block(FIPS_CT, e, 1'b1, 1'b0);
        vectors++;
        if (blk_count !== 32'd0) begin
            miscompares++;
            $display("FAIL blk_count_wrap: got %h expected 0", blk_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_back_pressure();
        test_ignored_key();
        test_reset_mid_settle();
        test_random();
`ifdef AES_STREAM_CNT_EN
        test_blk_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
